// File: rtl/acc_pkg.sv
// rtl/acc_pkg.sv - opcode, state and flag-index definitions for accumulator_unit
package acc_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LOAD = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_ADC  = 4'h3;
    localparam logic [3:0] OP_SUB  = 4'h4;
    localparam logic [3:0] OP_SBC  = 4'h5;
    localparam logic [3:0] OP_AND  = 4'h6;
    localparam logic [3:0] OP_OR   = 4'h7;
    localparam logic [3:0] OP_XOR  = 4'h8;
    localparam logic [3:0] OP_SHL  = 4'h9;
    localparam logic [3:0] OP_SHR  = 4'hA;
    localparam logic [3:0] OP_ROL  = 4'hB;
    localparam logic [3:0] OP_ROR  = 4'hC;
    localparam logic [3:0] OP_INC  = 4'hD;
    localparam logic [3:0] OP_DEC  = 4'hE;
    localparam logic [3:0] OP_MUL  = 4'hF;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    localparam int FLAG_V = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_Z = 3;

endpackage

// File: rtl/acc_mul_seq.sv
// rtl/acc_mul_seq.sv - iterative shift-add unsigned multiplier, one bit per cycle
module acc_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             last,
    output logic [WIDTH-1:0] prod_hi,
    output logic [WIDTH-1:0] prod_lo
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   sum;

    // lo starts as the multiplier and fills with product bits as it shifts out
    always_comb begin
        sum     = {1'b0, hi} + {1'b0, (lo[0] ? mcand : {WIDTH{1'b0}})};
        prod_hi = sum[WIDTH:1];
        prod_lo = {sum[0], lo[WIDTH-1:1]};
        last    = busy && (cnt == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand <= '0;
            hi    <= '0;
            lo    <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
        end else if (start) begin
            mcand <= b;
            hi    <= '0;
            lo    <= a;
            cnt   <= '0;
            busy  <= 1'b1;
        end else if (busy) begin
            hi    <= prod_hi;
            lo    <= prod_lo;
            cnt   <= cnt + CW'(1);
            if (last) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/accumulator_unit.sv
// rtl/accumulator_unit.sv - operate-on-accumulator unit with registered flags and iterative MUL
module accumulator_unit
    import acc_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             reg_clk,
    input  logic             reg_rst_n,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [3:0]       op_code,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] acc_out,
    output logic [WIDTH-1:0] acc_hi_out,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_v,
    output logic             done
);

    localparam int M = WIDTH - 1;

    state_t           state, state_next;
    logic [WIDTH-1:0] acc, acc_next;
    logic [WIDTH-1:0] acc_hi, acc_hi_next;
    logic [3:0]       flags, flags_next;
    logic             done_next;
    logic             mul_start;
    logic             mul_busy;
    logic             mul_last;
    logic [WIDTH-1:0] prod_hi;
    logic [WIDTH-1:0] prod_lo;
    logic [WIDTH:0]   wide;
    logic [WIDTH-1:0] res;
    logic             cin;

    acc_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk     (reg_clk),
        .rst_n   (reg_rst_n),
        .start   (mul_start),
        .a       (acc),
        .b       (data_in),
        .busy    (mul_busy),
        .last    (mul_last),
        .prod_hi (prod_hi),
        .prod_lo (prod_lo)
    );

    assign op_ready   = (state == ST_IDLE);
    assign acc_out    = acc;
    assign acc_hi_out = acc_hi;
    assign flag_z     = flags[FLAG_Z];
    assign flag_n     = flags[FLAG_N];
    assign flag_c     = flags[FLAG_C];
    assign flag_v     = flags[FLAG_V];

    always_comb begin
        state_next  = state;
        acc_next    = acc;
        acc_hi_next = acc_hi;
        flags_next  = flags;
        done_next   = 1'b0;
        mul_start   = 1'b0;
        wide        = '0;
        res         = acc;
        cin         = flags[FLAG_C] && (op_code == OP_ADC || op_code == OP_SBC);
        case (state)
            ST_IDLE: begin
                if (op_valid && op_code == OP_MUL) begin
                    mul_start  = 1'b1;
                    state_next = ST_MUL;
                end else if (op_valid) begin
                    done_next = 1'b1;
                    case (op_code)
                        OP_LOAD: res = data_in;
                        OP_ADD, OP_ADC: begin
                            wide = {1'b0, acc} + {1'b0, data_in} + {{WIDTH{1'b0}}, cin};
                            res  = wide[M:0];
                            flags_next[FLAG_C] = wide[WIDTH];
                            flags_next[FLAG_V] = (acc[M] == data_in[M]) && (res[M] != acc[M]);
                        end
                        // The extra top bit of the difference is the borrow
                        OP_SUB, OP_SBC: begin
                            wide = {1'b0, acc} - {1'b0, data_in} - {{WIDTH{1'b0}}, cin};
                            res  = wide[M:0];
                            flags_next[FLAG_C] = wide[WIDTH];
                            flags_next[FLAG_V] = (acc[M] != data_in[M]) && (res[M] != acc[M]);
                        end
                        OP_AND: res = acc & data_in;
                        OP_OR:  res = acc | data_in;
                        OP_XOR: res = acc ^ data_in;
                        OP_SHL: begin
                            res = {acc[M-1:0], 1'b0};
                            flags_next[FLAG_C] = acc[M];
                        end
                        OP_SHR: begin
                            res = {1'b0, acc[M:1]};
                            flags_next[FLAG_C] = acc[0];
                        end
                        OP_ROL: begin
                            res = {acc[M-1:0], acc[M]};
                            flags_next[FLAG_C] = acc[M];
                        end
                        OP_ROR: begin
                            res = {acc[0], acc[M:1]};
                            flags_next[FLAG_C] = acc[0];
                        end
                        OP_INC: begin
                            res = acc + WIDTH'(1);
                            flags_next[FLAG_V] = (acc == {1'b0, {M{1'b1}}});
                        end
                        OP_DEC: begin
                            res = acc - WIDTH'(1);
                            flags_next[FLAG_V] = (acc == {1'b1, {M{1'b0}}});
                        end
                        default: res = acc;
                    endcase
                    if (op_code != OP_NOP) begin
                        acc_next           = res;
                        flags_next[FLAG_Z] = (res == '0);
                        flags_next[FLAG_N] = res[M];
                    end
                end
            end
            ST_MUL: begin
                if (mul_last) begin
                    acc_next           = prod_lo;
                    acc_hi_next        = prod_hi;
                    flags_next[FLAG_Z] = ({prod_hi, prod_lo} == '0);
                    flags_next[FLAG_N] = prod_hi[M];
                    flags_next[FLAG_C] = (prod_hi != '0);
                    flags_next[FLAG_V] = 1'b0;
                    done_next          = 1'b1;
                    state_next         = ST_IDLE;
                end else if (!mul_busy) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge reg_clk or negedge reg_rst_n) begin
        if (!reg_rst_n) begin
            state  <= ST_IDLE;
            acc    <= '0;
            acc_hi <= '0;
            flags  <= '0;
            done   <= 1'b0;
        end else begin
            state  <= state_next;
            acc    <= acc_next;
            acc_hi <= acc_hi_next;
            flags  <= flags_next;
            done   <= done_next;
        end
    end

endmodule

// File: tb/tb_accumulator_unit.sv
// tb/tb_accumulator_unit.sv - table-driven scoreboard bench for accumulator_unit
module tb_accumulator_unit;
    import acc_pkg::*;

    logic       reg_clk = 1'b0;
    logic       reg_rst_n = 1'b0;
    logic       op_valid = 1'b0;
    logic [3:0] op_code = 4'h0;
    logic [7:0] data_in = 8'h00;
    logic       op_ready, flag_z, flag_n, flag_c, flag_v, done;
    logic [7:0] acc_out, acc_hi_out;

    accumulator_unit #(.WIDTH(8)) dut (
        .reg_clk    (reg_clk),
        .reg_rst_n  (reg_rst_n),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .op_code    (op_code),
        .data_in    (data_in),
        .acc_out    (acc_out),
        .acc_hi_out (acc_hi_out),
        .flag_z     (flag_z),
        .flag_n     (flag_n),
        .flag_c     (flag_c),
        .flag_v     (flag_v),
        .done       (done)
    );

    always #5 reg_clk = ~reg_clk;

    typedef struct {
        logic [3:0] op;
        logic [7:0] data;
        logic [7:0] acc;
        logic [3:0] zncv;
    } vec_t;

    typedef struct {
        logic [7:0] acc;
        logic [7:0] hi;
        logic [3:0] zncv;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    vec_t tbl[27];
    int   checks = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic [7:0] a, input logic [7:0] h, input logic [3:0] f);
        exp_t e;
        e.acc  = a;
        e.hi   = h;
        e.zncv = f;
        return e;
    endfunction

    task automatic issue(input logic [3:0] op, input logic [7:0] d, input logic push, input exp_t e);
        @(negedge reg_clk);
        op_code  = op;
        data_in  = d;
        op_valid = 1'b1;
        if (push) sb_q.push_back(e);
        @(posedge reg_clk);
        #1 op_valid = 1'b0;
    endtask

    // Every done pulse must match the oldest outstanding expectation
    always @(negedge reg_clk) begin
        if (reg_rst_n && done) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL done_without_op actual=1 required=0");
            end else begin
                mon_e = sb_q.pop_front();
                check("acc", acc_out, mon_e.acc);
                check("acc_hi", acc_hi_out, mon_e.hi);
                check("flags_zncv", {flag_z, flag_n, flag_c, flag_v}, mon_e.zncv);
            end
        end
    end

    initial begin
        tbl = '{
            '{OP_LOAD, 8'h7F, 8'h7F, 4'b0000},
            '{OP_ADD,  8'h01, 8'h80, 4'b0101},
            '{OP_LOAD, 8'hFF, 8'hFF, 4'b0101},
            '{OP_ADD,  8'h01, 8'h00, 4'b1010},
            '{OP_ADC,  8'h00, 8'h01, 4'b0000},
            '{OP_LOAD, 8'h03, 8'h03, 4'b0000},
            '{OP_SUB,  8'h05, 8'hFE, 4'b0110},
            '{OP_SBC,  8'h01, 8'hFC, 4'b0100},
            '{OP_LOAD, 8'h81, 8'h81, 4'b0100},
            '{OP_ROL,  8'hEE, 8'h03, 4'b0010},
            '{OP_ROR,  8'hEE, 8'h81, 4'b0110},
            '{OP_SHR,  8'hEE, 8'h40, 4'b0010},
            '{OP_SHL,  8'hEE, 8'h80, 4'b0100},
            '{OP_SHL,  8'hEE, 8'h00, 4'b1010},
            '{OP_DEC,  8'hEE, 8'hFF, 4'b0110},
            '{OP_INC,  8'hEE, 8'h00, 4'b1010},
            '{OP_LOAD, 8'h80, 8'h80, 4'b0110},
            '{OP_DEC,  8'hEE, 8'h7F, 4'b0011},
            '{OP_INC,  8'hEE, 8'h80, 4'b0111},
            '{OP_AND,  8'h0F, 8'h00, 4'b1011},
            '{OP_OR,   8'hA5, 8'hA5, 4'b0111},
            '{OP_XOR,  8'hFF, 8'h5A, 4'b0011},
            '{OP_NOP,  8'h33, 8'h5A, 4'b0011},
            '{OP_SUB,  8'h5A, 8'h00, 4'b1000},
            '{OP_SBC,  8'h01, 8'hFF, 4'b0110},
            '{OP_ADC,  8'h7F, 8'h7F, 4'b0010},
            '{OP_ADD,  8'h01, 8'h80, 4'b0101}
        };

        #3;
        check("reset_acc", acc_out, 8'h00);
        check("reset_acc_hi", acc_hi_out, 8'h00);
        check("reset_flags", {flag_z, flag_n, flag_c, flag_v}, 4'b0000);
        check("reset_ready", op_ready, 1'b1);
        check("reset_done", done, 1'b0);
        @(negedge reg_clk);
        reg_rst_n = 1'b1;

        for (int i = 0; i < 27; i++) begin
            issue(tbl[i].op, tbl[i].data, 1'b1, mk(tbl[i].acc, 8'h00, tbl[i].zncv));
        end

        // Multiply 0xC8 * 0x0F = 0x0BB8 with an ignored request while busy
        issue(OP_LOAD, 8'hC8, 1'b1, mk(8'hC8, 8'h00, 4'b0101));
        issue(OP_MUL, 8'h0F, 1'b1, mk(8'hB8, 8'h0B, 4'b0010));
        op_code = OP_LOAD;
        data_in = 8'hAA;
        for (int c = 1; c <= 8; c++) begin
            @(negedge reg_clk);
            check("mul_ready_low", op_ready, 1'b0);
            check("mul_no_early_done", done, 1'b0);
            op_valid = (c == 3);
            data_in  = (c == 3) ? 8'h55 : 8'hAA;
        end
        @(negedge reg_clk);
        op_valid = 1'b0;
        check("mul_ready_back", op_ready, 1'b1);
        check("mul_done_latency", done, 1'b1);
        issue(OP_ADD, 8'h01, 1'b1, mk(8'hB9, 8'h0B, 4'b0100));

        // Asynchronous reset mid-cycle
        @(posedge reg_clk);
        #2 reg_rst_n = 1'b0;
        #1;
        check("async_rst_acc", acc_out, 8'h00);
        check("async_rst_acc_hi", acc_hi_out, 8'h00);
        check("async_rst_flags", {flag_z, flag_n, flag_c, flag_v}, 4'b0000);
        check("async_rst_ready", op_ready, 1'b1);
        @(negedge reg_clk);
        reg_rst_n = 1'b1;

        // Reset at iteration 4 of a MUL, then LOAD on the first edge after release
        issue(OP_LOAD, 8'h07, 1'b1, mk(8'h07, 8'h00, 4'b0000));
        issue(OP_MUL, 8'h03, 1'b0, mk(8'h00, 8'h00, 4'b0000));
        repeat (3) @(posedge reg_clk);
        #2 reg_rst_n = 1'b0;
        #1;
        check("mulrst_acc", acc_out, 8'h00);
        check("mulrst_flags", {flag_z, flag_n, flag_c, flag_v}, 4'b0000);
        check("mulrst_ready", op_ready, 1'b1);
        check("mulrst_done", done, 1'b0);
        @(negedge reg_clk);
        reg_rst_n = 1'b1;
        op_code   = OP_LOAD;
        data_in   = 8'h12;
        op_valid  = 1'b1;
        sb_q.push_back(mk(8'h12, 8'h00, 4'b0000));
        @(posedge reg_clk);
        #1 op_valid = 1'b0;
        repeat (14) @(negedge reg_clk);
        check("scoreboard_drained", 16'(sb_q.size()), 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/accumulator_unit.md
Name: accumulator_unit

Overview:
- Parametrised next-generation accumulator for the microprocessor datapath.
- Replaces the plain load/enable accumulator register with an operate-on-accumulator unit: load, add/sub with carry, logic, shift/rotate, inc/dec, and a multi-cycle unsigned multiply.
- Results are written back into the accumulator. Status flags are registered.
- Sits between the ALU operand bus and the control unit. The control unit issues ops through a valid/ready handshake.

Parameters:
- WIDTH, 8, accumulator and operand width in bits; legal range is WIDTH >= 2.

Ports:
- reg_clk  input  1  single clock; all state changes on its rising edge.
- reg_rst_n  input  1  asynchronous, active-low reset.
- op_valid  input  1  op request; accepted in a cycle where op_valid && op_ready.
- op_ready  output  1  high when the unit can accept an op (IDLE state).
- op_code  input  4  operation select; encoding under Behaviour.
- data_in  input  WIDTH  operand B.
- acc_out  output  WIDTH  accumulator (low half of the product after MUL).
- acc_hi_out  output  WIDTH  high half of the last MUL product.
- flag_z  output  1  zero flag.
- flag_n  output  1  negative flag (result msb).
- flag_c  output  1  carry/borrow flag.
- flag_v  output  1  signed overflow flag.
- done  output  1  one-cycle pulse when an accepted op completes.

Behaviour:
- Reset (reg_rst_n low, asynchronous):
  - acc_out, acc_hi_out, all flags and done go to 0.
  - The state machine goes to IDLE, so op_ready = 1.
  - Reset may occur in any state, including mid-MUL. Any partial product is discarded.
- States:
  - IDLE: op_ready = 1.
  - MUL: op_ready = 0; iteration counter counts 0..WIDTH-1.
  - op_ready is decoded from state only, with no combinational path from op_valid.
- Single-cycle ops (every opcode except MUL):
  - Accepted at edge T. Results and flags are registered at T; done = 1 for the cycle following T.
  - The unit stays in IDLE, so back-to-back ops are accepted every cycle.
- Opcode encoding (acc = A, data_in = B, flag_c = C):
  - 0 NOP: no state change; done still pulses.
  - 1 LOAD: A <= B. Updates Z and N; C and V unchanged.
  - 2 ADD: {C,A} <= A+B. V = signed overflow.
  - 3 ADC: {C,A} <= A+B+C.
  - 4 SUB: A <= A-B. C = 1 on borrow (unsigned A < B); V = signed overflow.
  - 5 SBC: A <= A-B-C, with the same C/V rules as SUB.
  - 6 AND, 7 OR, 8 XOR: bitwise. Update Z and N; C and V unchanged.
  - 9 SHL: logical left; C = old msb.
  - A SHR: logical right; C = old lsb.
  - B ROL, C ROR: rotate by 1; C = the bit moved across the end.
  - For shifts and rotates, B is ignored and V is unchanged.
  - D INC, E DEC: update Z, N and V (V set on 0x7F->0x80 or 0x80->0x7F at WIDTH=8); C unchanged.
  - F MUL: unsigned multiply, {acc_hi, A} <= A*B.
- Z and N are computed on every op except NOP, from the new A (for MUL, from the full 2*WIDTH product).
- acc_hi_out is written only by MUL and reset.
- MUL sequencing:
  - On acceptance: capture B into an internal multiplicand register, go to MUL, set op_ready = 0.
  - Shift-add, one bit per cycle, WIDTH cycles.
  - On the last iteration, write the product and return to IDLE; done pulses the following cycle.
  - Total latency is WIDTH+1 cycles from the accept edge to done.
  - Flags after MUL: C = (acc_hi != 0), V = 0.
- Inputs during MUL:
  - op_valid while busy is ignored (not accepted, not queued).
  - Changes on data_in or op_code during MUL have no effect.
- acc_out is not updated mid-MUL; intermediate sums live in internal registers.
- Arithmetic is modulo 2^WIDTH. Carry and borrow come from a WIDTH+1-bit internal sum.

Decomposition:
- Package acc_pkg holds:
  - 4-bit opcode localparams OP_NOP..OP_MUL;
  - the state encoding (ST_IDLE, ST_MUL);
  - the flag bit-index constants.
- One sub-module, acc_mul_seq, holds the iterative shift-add multiplier:
  - ports: start, a, b, busy, last, prod_hi, prod_lo;
  - parametrised by WIDTH.
- The top level holds the handshake, the single-cycle ops and the flag registers.

Test Plan (WIDTH=8):
- Reset: pull reg_rst_n low asynchronously mid-cycle -> acc_out=0x00, acc_hi_out=0x00, all flags 0, op_ready=1 before the next edge.
- Signed overflow: LOAD 0x7F, then ADD 0x01 -> acc=0x80, N=1, V=1, C=0, Z=0; done pulses once per op.
- Carry chain: LOAD 0xFF, then ADD 0x01 -> acc=0x00, Z=1, C=1. Next ADC 0x00 -> acc=0x01, C=0, Z=0.
- Borrow and rotate:
  - LOAD 0x03, SUB 0x05 -> acc=0xFE, C=1, N=1.
  - LOAD 0x81, ROL -> acc=0x03, C=1.
- Multiply: LOAD 0xC8, then MUL 0x0F.
  - op_ready stays low for 8 cycles.
  - An op_valid pulse (LOAD 0x55) during busy is ignored.
  - done pulses 9 cycles after accept: acc_hi_out=0x0B, acc_out=0xB8, C=1, Z=0.
- Reset mid-MUL: assert reg_rst_n low at iteration 4 -> all outputs 0, no done pulse. A LOAD 0x12 issued on the first edge after release is accepted -> acc=0x12.
